// File: rtl/wordline_sequencer.sv
// Clocked row decoder: one access at a time, precharge -> timed one-hot wordline pulse -> done.
// Latency P+W+1 cycles from accept to done; req_ready is high only in IDLE, so busy periods stall the requester.
module wordline_sequencer #(
    parameter int ADDR_W        = 3,
    parameter int NUM_WL        = 8,
    parameter int PRECHARGE_CYC = 1,
    parameter int WL_PULSE_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    output logic [NUM_WL-1:0] wl,
    output logic              precharge,
    output logic              sense_en,
    output logic              write_en,
    output logic              done,
    output logic              err
);

    localparam int MAX_CYC = (PRECHARGE_CYC > WL_PULSE_CYC) ? PRECHARGE_CYC : WL_PULSE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0]  PRE_LOAD   = CNT_W'(PRECHARGE_CYC - 1);
    localparam logic [CNT_W-1:0]  PULSE_LOAD = CNT_W'(WL_PULSE_CYC - 1);
    localparam logic [ADDR_W:0]   WL_LIMIT   = (ADDR_W + 1)'(NUM_WL);
    localparam logic [NUM_WL-1:0] WL_ONE     = NUM_WL'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRECH,
        ACTIVE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic               we_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wl        <= '0;
            precharge <= 1'b0;
            sense_en  <= 1'b0;
            write_en  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        // Unpopulated rows are rejected without touching the array.
                        if ({1'b0, req_addr} < WL_LIMIT) begin
                            addr_q    <= req_addr;
                            we_q      <= req_we;
                            state     <= PRECH;
                            precharge <= 1'b1;
                            req_ready <= 1'b0;
                            cnt       <= PRE_LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                PRECH: begin
                    if (cnt == '0) begin
                        state     <= ACTIVE;
                        precharge <= 1'b0;
                        wl        <= WL_ONE << addr_q;
                        write_en  <= we_q;
                        sense_en  <= !we_q;
                        cnt       <= PULSE_LOAD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ACTIVE: begin
                    if (cnt == '0) begin
                        state     <= IDLE;
                        wl        <= '0;
                        write_en  <= 1'b0;
                        sense_en  <= 1'b0;
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wordline_sequencer.md
Name: wordline_sequencer

Overview:
- Parametrised, clocked successor to the SRAM row address decoder.
- Accepts one access request at a time through a valid/ready handshake and decodes an ADDR_W-bit row address onto NUM_WL registered, glitch-free one-hot wordlines.
- Sequences each access as precharge, then a timed wordline pulse, then done, and drives precharge, sense-enable and write-enable strobes to the bit-cell array.
- Sits between the memory controller front end and the bit-cell array.

Parameters:
- ADDR_W, 3: row address width.
- NUM_WL, 8: number of implemented wordlines. Legal range is 2 to 2**ADDR_W; rows NUM_WL to 2**ADDR_W-1 are unpopulated.
- PRECHARGE_CYC, 1: bitline precharge duration in cycles. Must be at least 1.
- WL_PULSE_CYC, 2: wordline-high duration in cycles. Must be at least 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (IDLE only).
- req_addr  input  ADDR_W  row address, sampled at accept.
- req_we  input  1  1 = write, 0 = read; sampled at accept.
- wl  output  NUM_WL  registered one-hot wordlines.
- precharge  output  1  bitline precharge strobe.
- sense_en  output  1  sense-amp enable; high with wl on reads.
- write_en  output  1  write-driver enable; high with wl on writes.
- done  output  1  one-cycle pulse when an access completes.
- err  output  1  one-cycle pulse when an address is out of range.

Behaviour:
- Reset values, with rst high at an edge: state=IDLE, counters=0, wl=0, precharge=0, sense_en=0, write_en=0, done=0, err=0, req_ready=0.
  - req_ready is 1 in the first cycle after rst deasserts.
- Reset has priority over every other event. Reset mid-access aborts the access: wl drops on the same edge, and no done or err is produced.
- All outputs are registered. No combinational path exists from any input to any output.
- Accept: req_valid && req_ready at an edge (cycle T). req_addr and req_we are latched, and req_ready goes 0 from T+1. req_valid while busy is ignored; the requester holds the request.
- FSM states: IDLE, PRECH, ACTIVE.
  - IDLE -> PRECH on accept of an address below NUM_WL.
  - IDLE stays in IDLE on accept of an address at or above NUM_WL. err=1 for cycle T+1 only, req_ready stays 1 at T+1, and wl, precharge and enables never assert.
  - PRECH: precharge=1 and wl=0 for PRECHARGE_CYC cycles, T+1..T+P. Then go to ACTIVE.
  - ACTIVE: wl[addr]=1 and exactly one bit is high. Either write_en=req_we or sense_en=!req_we. Holds for WL_PULSE_CYC cycles, T+P+1..T+P+W. precharge=0. Then go to IDLE.
  - Return to IDLE: in cycle T+P+W+1, done=1 and req_ready=1, and wl and enables are 0.
- Back-to-back: a new request may be accepted in the done cycle. Maximum throughput is one access per P+W+1 cycles.
- Invariants, on every cycle:
  - popcount(wl) <= 1.
  - precharge and wl are never simultaneously high.
  - sense_en and write_en are never simultaneously high.
  - done and err are never simultaneously high.
- Duration counter: width clog2(max(P,W)+1). It loads at each state entry and counts down, and never wraps.

Test Plan:
- Defaults, accept addr=5 we=1 at cycle 0 -> precharge=1 at cycle 1; wl=8'b0010_0000 and write_en=1 at cycles 2-3; done=1, wl=0, req_ready=1 at cycle 4; sense_en never high.
- Defaults, read addr=0 accepted in the done cycle of a write to addr=7 -> wl=8'b1000_0000 then later 8'b0000_0001 with no overlap; second done exactly 4 cycles after the first.
- NUM_WL=6, accept addr=6 -> err=1 at cycle 1 only, wl stays 0, no precharge, req_ready=1 at cycle 1; a following addr=2 access completes normally.
- Defaults, rst=1 at cycle 2 of an access to addr=3 -> wl=0 from cycle 3, no done; req_ready=1 the cycle after rst falls; a new access completes with correct timing.
- PRECHARGE_CYC=3, WL_PULSE_CYC=1, req_valid held high continuously -> only IDLE-cycle handshakes accepted; precharge high 3 cycles, wl high 1 cycle, done every 5 cycles.
- Defaults, sweep all 8 addresses read and write -> wl equals 1<<addr on each access, and all invariants hold every cycle.
